// File: rtl/dynamixel_bus_scheduler_if.sv
// Bus-side signal bundle of the Dynamixel TX scheduler: position inputs from motion
// logic, the sync-write generator handshake and the configuration writer handshake.
interface dynamixel_bus_scheduler_if;
   logic [31:0] position1;
   logic [31:0] position2;
   logic [31:0] position3;
   logic [31:0] position4;
   logic        position_valid;
   logic        config_request;
   logic        config_done;
   logic        sync_done;
   logic        sync_send;
   logic [31:0] sync_position1;
   logic [31:0] sync_position2;
   logic [31:0] sync_position3;
   logic [31:0] sync_position4;
   logic        config_grant;
   logic        busy;
   logic [7:0]  error_count;

   // Scheduler side.
   modport slave (
      input  position1, position2, position3, position4, position_valid,
      input  config_request, config_done, sync_done,
      output sync_send, sync_position1, sync_position2, sync_position3, sync_position4,
      output config_grant, busy, error_count
   );

   // Motion logic / packet generator side.
   modport master (
      output position1, position2, position3, position4, position_valid,
      output config_request, config_done, sync_done,
      input  sync_send, sync_position1, sync_position2, sync_position3, sync_position4,
      input  config_grant, busy, error_count
   );
endinterface

// File: rtl/dynamixel_bus_scheduler.sv
// Owner of the half-duplex Dynamixel TX bus. Latches position targets, schedules periodic
// sync-write refreshes, alternates fairly with configuration traffic, inserts a turnaround
// gap after every packet and recovers from a stalled transmitter with a timeout.
module dynamixel_bus_scheduler #(
   parameter int unsigned period_clocks  = 100000,
   parameter int unsigned gap_clocks     = 16,
   parameter int unsigned timeout_clocks = 1000000
) (
   input logic                      clock,
   input logic                      reset_n,
   dynamixel_bus_scheduler_if.slave bus
);

   localparam int unsigned PeriodW  = (period_clocks > 1) ? $clog2(period_clocks) : 1;
   localparam int unsigned GapW     = (gap_clocks > 1) ? $clog2(gap_clocks) : 1;
   localparam int unsigned TimeoutW = (timeout_clocks > 1) ? $clog2(timeout_clocks) : 1;

   localparam logic [PeriodW-1:0]  PeriodLast  = PeriodW'(period_clocks - 1);
   localparam logic [GapW-1:0]     GapLast     = GapW'(gap_clocks - 1);
   localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(timeout_clocks - 1);

   typedef enum logic [1:0] {StIdle, StSyncWait, StConfigWait, StGap} state_e;

   state_e               state_q, state_d;
   logic [PeriodW-1:0]   period_q, period_d;
   logic [GapW-1:0]      gap_q, gap_d;
   logic [TimeoutW-1:0]  timeout_q, timeout_d;
   logic [3:0][31:0]     shadow_q, shadow_d;
   logic [3:0][31:0]     snap_q, snap_d;
   logic                 armed_q, armed_d;
   logic                 dirty_q, dirty_d;
   logic                 last_cfg_q, last_cfg_d;
   logic                 sync_send_q, sync_send_d;
   logic                 grant_q, grant_d;
   logic                 busy_q, busy_d;
   logic [7:0]           err_q, err_d;
   logic                 dirty_clr;
   logic                 period_wrap;
   logic                 timeout_hit;

   assign period_wrap = (period_q == PeriodLast);
   assign timeout_hit = (timeout_q == TimeoutLast);

   assign bus.sync_send      = sync_send_q;
   assign bus.sync_position1 = snap_q[0];
   assign bus.sync_position2 = snap_q[1];
   assign bus.sync_position3 = snap_q[2];
   assign bus.sync_position4 = snap_q[3];
   assign bus.config_grant   = grant_q;
   assign bus.busy           = busy_q;
   assign bus.error_count    = err_q;

   // Next-state: shadow/refresh bookkeeping, arbitration and the packet FSM.
   always_comb begin
      state_d     = state_q;
      period_d    = period_wrap ? '0 : period_q + PeriodW'(1);
      gap_d       = gap_q;
      timeout_d   = timeout_q;
      shadow_d    = shadow_q;
      snap_d      = snap_q;
      armed_d     = armed_q;
      last_cfg_d  = last_cfg_q;
      sync_send_d = 1'b0;
      grant_d     = grant_q;
      busy_d      = busy_q;
      err_d       = err_q;
      dirty_clr   = 1'b0;

      if (bus.position_valid) begin
         shadow_d = {bus.position4, bus.position3, bus.position2, bus.position1};
         armed_d  = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            // On contention, sync wins only if config had the previous turn.
            if (dirty_q && (last_cfg_q || !bus.config_request)) begin
               sync_send_d = 1'b1;
               snap_d      = shadow_q;
               dirty_clr   = 1'b1;
               last_cfg_d  = 1'b0;
               busy_d      = 1'b1;
               timeout_d   = '0;
               state_d     = StSyncWait;
            end else if (bus.config_request) begin
               grant_d    = 1'b1;
               last_cfg_d = 1'b1;
               busy_d     = 1'b1;
               timeout_d  = '0;
               state_d    = StConfigWait;
            end
         end
         StSyncWait: begin
            if (bus.sync_done) begin
               gap_d   = '0;
               state_d = StGap;
            end else if (timeout_hit) begin
               err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
               gap_d   = '0;
               state_d = StGap;
            end else begin
               timeout_d = timeout_q + TimeoutW'(1);
            end
         end
         StConfigWait: begin
            if (bus.config_done || !bus.config_request) begin
               grant_d = 1'b0;
               gap_d   = '0;
               state_d = StGap;
            end else if (timeout_hit) begin
               err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
               grant_d = 1'b0;
               gap_d   = '0;
               state_d = StGap;
            end else begin
               timeout_d = timeout_q + TimeoutW'(1);
            end
         end
         StGap: begin
            if (gap_q == GapLast) begin
               busy_d  = 1'b0;
               state_d = StIdle;
            end else begin
               gap_d = gap_q + GapW'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      // A new update or refresh in the same cycle as a send keeps dirty set for a follow-up.
      dirty_d = (dirty_q && !dirty_clr) || bus.position_valid || (period_wrap && armed_q);
   end

   // State and output registers; reset clears everything including pending refreshes.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         period_q    <= '0;
         gap_q       <= '0;
         timeout_q   <= '0;
         shadow_q    <= '0;
         snap_q      <= '0;
         armed_q     <= 1'b0;
         dirty_q     <= 1'b0;
         last_cfg_q  <= 1'b0;
         sync_send_q <= 1'b0;
         grant_q     <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 8'd0;
      end else begin
         state_q     <= state_d;
         period_q    <= period_d;
         gap_q       <= gap_d;
         timeout_q   <= timeout_d;
         shadow_q    <= shadow_d;
         snap_q      <= snap_d;
         armed_q     <= armed_d;
         dirty_q     <= dirty_d;
         last_cfg_q  <= last_cfg_d;
         sync_send_q <= sync_send_d;
         grant_q     <= grant_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_dynamixel_bus_scheduler.sv
// Scoreboard bench for dynamixel_bus_scheduler: directed stimulus pushes the expected packet
// starts (kind, cycle, snapshot) into a queue; a negedge monitor pops and compares them.
module tb_dynamixel_bus_scheduler;

   typedef struct {
      bit               is_sync;
      int unsigned      cyc;
      logic [3:0][31:0] p;
   } exp_t;

   logic        clock   = 1'b0;
   logic        reset_n = 1'b0;
   int unsigned cyc;
   int          checks   = 0;
   int          failures = 0;
   int          n_sync   = 0;
   logic        grant_prev = 1'b0;
   exp_t        exp_q[$];

   logic [3:0][31:0] p0, p1, p2, p3, p4, p5, p6;

   dynamixel_bus_scheduler_if bus ();

   dynamixel_bus_scheduler #(
      .period_clocks  (1000),
      .gap_clocks     (4),
      .timeout_clocks (200)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   // Edges since the last reset release.
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic push(input bit is_sync, input int unsigned c, input logic [3:0][31:0] p);
      exp_t e;
      e.is_sync = is_sync;
      e.cyc     = c;
      e.p       = p;
      exp_q.push_back(e);
   endtask

   task automatic score(input bit is_sync);
      exp_t             e;
      logic [3:0][31:0] act;
      act = {bus.sync_position4, bus.sync_position3, bus.sync_position2, bus.sync_position1};
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_packet: got %s at cycle %0d, required none",
                  is_sync ? "sync" : "grant", cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.is_sync != is_sync || e.cyc != cyc || (is_sync && act !== e.p)) begin
            failures++;
            $display("FAIL packet: got %s @%0d pos=%h, required %s @%0d pos=%h",
                     is_sync ? "sync" : "grant", cyc, act,
                     e.is_sync ? "sync" : "grant", e.cyc, e.p);
         end
      end
   endtask

   // Monitor: every sync_send pulse and every rising config_grant is a packet start.
   always @(negedge clock) begin
      if (reset_n) begin
         if (bus.sync_send === 1'b1) begin
            n_sync++;
            score(1'b1);
         end
         if (bus.config_grant === 1'b1 && grant_prev !== 1'b1) score(1'b0);
      end
      grant_prev = bus.config_grant;
   end

   // Advance to 1 ns after edge n.
   task automatic goto(input int unsigned n);
      while (cyc < n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic pulse_valid(input int unsigned k, input logic [3:0][31:0] p);
      goto(k - 1);
      bus.position1      = p[0];
      bus.position2      = p[1];
      bus.position3      = p[2];
      bus.position4      = p[3];
      bus.position_valid = 1'b1;
      goto(k);
      bus.position_valid = 1'b0;
   endtask

   task automatic pulse_sdone(input int unsigned k);
      goto(k - 1);
      bus.sync_done = 1'b1;
      goto(k);
      bus.sync_done = 1'b0;
   endtask

   task automatic pulse_cdone(input int unsigned k);
      goto(k - 1);
      bus.config_done = 1'b1;
      goto(k);
      bus.config_done = 1'b0;
   endtask

   initial begin
      p0 = '0;
      p1 = {32'h0, 32'h0, 32'h0, 32'h0000_0800};
      p2 = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      p3 = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
      p4 = {32'h0000_0FA0, 32'h0000_0BB8, 32'h0000_07D0, 32'h0000_03E8};
      p5 = {32'h8, 32'h7, 32'h6, 32'h5};
      p6 = {32'h80, 32'h70, 32'h60, 32'h50};
      bus.position1      = '0;
      bus.position2      = '0;
      bus.position3      = '0;
      bus.position4      = '0;
      bus.position_valid = 1'b0;
      bus.config_request = 1'b0;
      bus.config_done    = 1'b0;
      bus.sync_done      = 1'b0;

      // Reset values.
      #12;
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_sync_send", {31'd0, bus.sync_send}, 32'd0);
      check("rst_grant", {31'd0, bus.config_grant}, 32'd0);
      check("rst_error_count", {24'd0, bus.error_count}, 32'd0);
      #20 reset_n = 1'b1;

      // Unarmed: period wraps at 1000/2000/3000 must not trigger a refresh.
      goto(3000);
      check("unarmed_no_sync", n_sync, 0);
      check("unarmed_busy", {31'd0, bus.busy}, 32'd0);
      check("unarmed_pos1", bus.sync_position1, 32'd0);
      check("unarmed_error_count", {24'd0, bus.error_count}, 32'd0);

      // Single update: valid at 3005 -> send after 3006, done at 3056, idle after 3060.
      push(1'b1, 3006, p1);
      pulse_valid(3005, p1);
      goto(3007);
      check("send_one_cycle", {31'd0, bus.sync_send}, 32'd0);
      check("busy_in_wait", {31'd0, bus.busy}, 32'd1);
      pulse_sdone(3056);
      goto(3059);
      check("busy_in_gap", {31'd0, bus.busy}, 32'd1);
      goto(3060);
      check("busy_after_gap", {31'd0, bus.busy}, 32'd0);

      // Periodic refresh: wraps at 4000/5000/6000 resend the unchanged snapshot.
      for (int i = 0; i < 3; i++) push(1'b1, 4001 + 1000 * i, p1);
      for (int i = 0; i < 3; i++) pulse_sdone(4011 + 1000 * i);

      // Arbitration: both pending after a sync -> config first, then alternate.
      push(1'b1, 6101, p2);
      push(1'b0, 6115, p0);
      push(1'b1, 6135, p3);
      push(1'b0, 6145, p0);
      push(1'b1, 6155, p4);
      push(1'b1, 7001, p4);
      pulse_valid(6100, p2);
      pulse_sdone(6110);
      goto(6111);
      bus.config_request = 1'b1;
      pulse_valid(6112, p3);
      pulse_cdone(6130);
      check("grant_drop_on_done", {31'd0, bus.config_grant}, 32'd0);
      check("busy_after_cfg_done", {31'd0, bus.busy}, 32'd1);
      pulse_sdone(6140);
      pulse_valid(6142, p4);
      pulse_cdone(6150);
      goto(6155);
      bus.config_request = 1'b0;
      pulse_sdone(6160);
      pulse_sdone(7010);

      // Sync timeout: send at 8001 never completes -> gap after 8201.
      push(1'b1, 8001, p4);
      goto(8200);
      check("err_before_timeout", {24'd0, bus.error_count}, 32'd0);
      check("busy_before_timeout", {31'd0, bus.busy}, 32'd1);
      goto(8201);
      check("err_after_timeout", {24'd0, bus.error_count}, 32'd1);
      goto(8205);
      check("busy_after_timeout_gap", {31'd0, bus.busy}, 32'd0);

      // Config request dropped mid-grant releases the bus.
      push(1'b0, 8211, p0);
      goto(8210);
      bus.config_request = 1'b1;
      goto(8215);
      bus.config_request = 1'b0;
      goto(8216);
      check("grant_drop_on_request_low", {31'd0, bus.config_grant}, 32'd0);

      // Collision: update on the send edge -> old snapshot, then follow-up with new values.
      push(1'b1, 8231, p5);
      push(1'b1, 8245, p6);
      pulse_valid(8230, p5);
      pulse_valid(8231, p6);
      pulse_sdone(8240);
      pulse_sdone(8250);

      // Asynchronous reset during CONFIG_WAIT.
      push(1'b0, 8261, p0);
      goto(8260);
      bus.config_request = 1'b1;
      goto(8270);
      check("grant_before_reset", {31'd0, bus.config_grant}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("reset_grant", {31'd0, bus.config_grant}, 32'd0);
      check("reset_busy", {31'd0, bus.busy}, 32'd0);
      check("reset_error_count", {24'd0, bus.error_count}, 32'd0);
      check("reset_pos1", bus.sync_position1, 32'd0);
      @(negedge clock);
      @(negedge clock);
      #2 reset_n = 1'b1;

      // Saturation: request held, config_done never comes -> timeout every 205 cycles.
      for (int j = 0; j <= 256; j++) push(1'b0, 1 + 205 * j, p0);
      goto(200);
      check("sat_err_0", {24'd0, bus.error_count}, 32'd0);
      goto(201);
      check("sat_err_1", {24'd0, bus.error_count}, 32'd1);
      goto(201 + 205 * 253);
      check("sat_err_254", {24'd0, bus.error_count}, 32'd254);
      goto(201 + 205 * 254);
      check("sat_err_255", {24'd0, bus.error_count}, 32'd255);
      goto(201 + 205 * 255);
      check("sat_err_stays_255", {24'd0, bus.error_count}, 32'd255);
      goto(52482);
      bus.config_request = 1'b0;
      goto(52490);
      check("queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
